ysyx_25010008_sram_slave: RTL and testbench
===========================================

YSYX_25010008_SRAM_SLAVE -- requirements
Module: ysyx_25010008_sram_slave

Interface
REQ-001 SHALL have parameters: BASE, 32'h8000_0000, byte address of word 0; DEPTH_LOG2, 12, log2 of word count.
REQ-002 SHALL have ports: clock in 1, sole clock; reset in 1, synchronous, active-high.
REQ-003 SHALL have read-address ports: araddr in 32; arvalid in 1; arready out 1.
REQ-004 SHALL have read-data ports: rdata out 32; rresp out 2; rvalid out 1; rready in 1.
REQ-005 SHALL have write-address ports: awaddr in 32; awvalid in 1; awready out 1.
REQ-006 SHALL have write-data ports: wdata in 32; wstrb in 4, per-byte-lane enable; wvalid in 1; wready out 1.
REQ-007 SHALL have write-response ports: bresp out 2; bvalid out 1; bready in 1.

Function
REQ-008 SHALL hold 2^DEPTH_LOG2 32-bit words; word index = (addr-BASE)[DEPTH_LOG2+1:2]; addr[1:0] ignored.
REQ-009 SHALL treat addr outside [BASE, BASE+4*2^DEPTH_LOG2) as out of range: no memory access, resp 2'b10 (SLVERR); in range resp 2'b00.
REQ-010 SHALL use FSM states IDLE, R_DELAY, R_RESP, W_DATA, W_DELAY, B_RESP.
REQ-011 IDLE: arready=1; awready=!arvalid; all other readies and valids 0.
REQ-012 AR handshake (arvalid&arready): latch address -> R_DELAY; AR wins over AW in the same cycle, AW stays pending.
REQ-013 AW handshake: latch address -> W_DATA; wready=1 only in W_DATA.
REQ-014 W handshake: commit bytes with wstrb[i]=1 to lanes [8i+7:8i] at that edge; wstrb=0 commits nothing, response still OKAY -> W_DELAY.
REQ-015 R_DELAY/W_DELAY: count down delay D (REQ-022); at zero -> R_RESP/B_RESP; D=0 gives one cycle in the delay state.
REQ-016 Read latency: rvalid rises exactly 2+D cycles after the AR handshake edge.
REQ-017 R_RESP: rvalid=1; rdata/rresp stable until rvalid&rready; out-of-range rdata=0; on handshake -> IDLE, rvalid=0 next cycle.
REQ-018 B_RESP: bvalid=1; bresp stable until bvalid&bready; then -> IDLE.
REQ-019 Read data SHALL reflect all writes committed before the AR handshake (no stale data).
REQ-020 Back-to-back: new AR/AW SHALL be accepted in the IDLE cycle after a response handshake; throughput is one transaction per 4+D cycles minimum.

Reset
REQ-021 On reset: state IDLE, rvalid=0, bvalid=0, wready=0, rdata=0, rresp=0, bresp=0, delay counter 0; arready=1 the first cycle after reset deasserts; memory contents unchanged; in-flight transaction abandoned; write without completed W handshake not committed.

Configuration
REQ-022 Macro YSYX_25010008_SRAM_RAND_DELAY_EN: defined -> D = low 3 bits of an 8-bit maximal-length LFSR (seed 8'h5A on reset, advances every cycle), sampled at AR or W handshake, D in 0..7; undefined -> D=0 always, no LFSR logic.

Verification
REQ-023 Macro undefined, write awaddr=0x8000_0010 wdata=0xDEADBEEF wstrb=4'hF, then read 0x8000_0010 -> bresp=0, rdata=0xDEADBEEF, rresp=0, rvalid 2 cycles after AR handshake.
REQ-024 Memory 0x11223344 at 0x8000_0020, write wdata=0xAABBCCDD wstrb=4'b0010, read back -> rdata=0x1122CC44.
REQ-025 araddr=0x7FFF_FFFC and awaddr=BASE+0x4000 (DEPTH_LOG2=12) -> rresp=2'b10 rdata=0, bresp=2'b10, memory unchanged.
REQ-026 arvalid and awvalid both high in IDLE -> read completes first, awready=0 that cycle, write accepted in IDLE after R handshake; rready low 5 cycles -> rdata/rresp held stable.
REQ-027 Reset asserted during W_DATA before wvalid -> next cycle IDLE, bvalid=0; later read of that address returns old value.
REQ-028 Macro defined, 100 random reads/writes -> every rvalid/bvalid within 2..9 cycles of handshake, data matches scoreboard.

Source files
------------

// File: rtl/ysyx_25010008_sram_slave_if.sv
// rtl/ysyx_25010008_sram_slave_if.sv - AXI-Lite style read/write channel bundle for the SRAM slave
interface ysyx_25010008_sram_slave_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_25010008_sram_slave.sv
// rtl/ysyx_25010008_sram_slave.sv - single-port word SRAM behind an AXI-Lite style slave FSM
// Optional macro YSYX_25010008_SRAM_RAND_DELAY_EN: LFSR-driven 0..7 cycle response delay.
module ysyx_25010008_sram_slave #(
   parameter logic [31:0] BASE       = 32'h8000_0000,
   parameter int          DEPTH_LOG2 = 12
) (
   input  logic                             clock,
   input  logic                             reset,
   ysyx_25010008_sram_slave_if.slave        io_bus
);
   localparam int          DEPTH       = 1 << DEPTH_LOG2;
   localparam logic [29:0] BASE_W      = BASE[31:2];
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE, R_DELAY, R_RESP, W_DATA, W_DELAY, B_RESP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [29:0] r_raddr;
   logic [29:0] r_waddr;
   logic [2:0]  r_cnt;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;
   logic [1:0]  r_bresp;
   logic [31:0] r_mem [0:DEPTH-1];

   logic        w_arready;
   logic        w_awready;
   logic        w_wready;
   logic        w_rvalid;
   logic        w_bvalid;
   logic        w_ar_hs;
   logic        w_aw_hs;
   logic        w_w_hs;
   logic [2:0]  w_delay;
   logic [29:0] w_roff;
   logic [29:0] w_woff;
   logic        w_rin;
   logic        w_win;

`ifdef YSYX_25010008_SRAM_RAND_DELAY_EN
   logic [7:0] r_lfsr;

   // x^8+x^6+x^5+x^4+1, free-running so the sampled delay looks random per transaction
   always_ff @(posedge clock) begin
      if (reset) r_lfsr <= 8'h5A;
      else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   end

   assign w_delay = r_lfsr[2:0];
`else
   assign w_delay = 3'd0;
`endif

   // Word-granular range test; the high offset bits must be zero to hit the array
   assign w_roff = r_raddr - BASE_W;
   assign w_woff = r_waddr - BASE_W;
   assign w_rin  = (r_raddr >= BASE_W) && (w_roff[29:DEPTH_LOG2] == '0);
   assign w_win  = (r_waddr >= BASE_W) && (w_woff[29:DEPTH_LOG2] == '0);

   assign w_ar_hs = (r_state == IDLE) && io_bus.arvalid;
   assign w_aw_hs = (r_state == IDLE) && !io_bus.arvalid && io_bus.awvalid;
   assign w_w_hs  = (r_state == W_DATA) && io_bus.wvalid;

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_arready = 1'b0;
      w_awready = 1'b0;
      w_wready  = 1'b0;
      w_rvalid  = 1'b0;
      w_bvalid  = 1'b0;
      case (r_state)
         IDLE: begin
            w_arready = 1'b1;
            w_awready = !io_bus.arvalid;
            if (w_ar_hs)      w_next = R_DELAY;
            else if (w_aw_hs) w_next = W_DATA;
         end
         R_DELAY: if (r_cnt == 3'd0) w_next = R_RESP;
         R_RESP: begin
            w_rvalid = 1'b1;
            if (io_bus.rready) w_next = IDLE;
         end
         W_DATA: begin
            w_wready = 1'b1;
            if (w_w_hs) w_next = W_DELAY;
         end
         W_DELAY: if (r_cnt == 3'd0) w_next = B_RESP;
         B_RESP: begin
            w_bvalid = 1'b1;
            if (io_bus.bready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_raddr <= '0;
         r_waddr <= '0;
         r_cnt   <= 3'd0;
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
         r_bresp <= RESP_OKAY;
      end else begin
         if (w_ar_hs) begin
            r_raddr <= io_bus.araddr[31:2];
            r_cnt   <= w_delay;
         end
         if (w_aw_hs) r_waddr <= io_bus.awaddr[31:2];
         if (w_w_hs) begin
            r_bresp <= w_win ? RESP_OKAY : RESP_SLVERR;
            r_cnt   <= w_delay;
         end
         if ((r_state == R_DELAY || r_state == W_DELAY) && r_cnt != 3'd0)
            r_cnt <= r_cnt - 3'd1;
         // No write can land between AR and here, so reading at the end of the delay is coherent
         if (r_state == R_DELAY && r_cnt == 3'd0) begin
            r_rdata <= w_rin ? r_mem[w_roff[DEPTH_LOG2-1:0]] : '0;
            r_rresp <= w_rin ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Storage keeps its contents across reset
   always_ff @(posedge clock) begin
      if (!reset && w_w_hs && w_win) begin
         for (int i = 0; i < 4; i++) begin
            if (io_bus.wstrb[i])
               r_mem[w_woff[DEPTH_LOG2-1:0]][8*i +: 8] <= io_bus.wdata[8*i +: 8];
         end
      end
   end

   assign io_bus.arready = w_arready;
   assign io_bus.awready = w_awready;
   assign io_bus.wready  = w_wready;
   assign io_bus.rvalid  = w_rvalid;
   assign io_bus.bvalid  = w_bvalid;
   assign io_bus.rdata   = r_rdata;
   assign io_bus.rresp   = r_rresp;
   assign io_bus.bresp   = r_bresp;
endmodule

// File: tb/tb_ysyx_25010008_sram_slave.sv
// tb/tb_ysyx_25010008_sram_slave.sv - scoreboard bench for the SRAM slave
module tb_ysyx_25010008_sram_slave;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          BOUND = 40;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   r_hs_cyc = 0;
   int   w_hs_cyc = 0;
   exp_t        rq[$];
   logic [1:0]  bq[$];
   logic [31:0] model [0:4095];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   ysyx_25010008_sram_slave_if bus();

   ysyx_25010008_sram_slave #(.BASE(BASE), .DEPTH_LOG2(12)) dut (
      .clock  (clock),
      .reset  (reset),
      .io_bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_lat(input string tag, input int lat);
`ifdef YSYX_25010008_SRAM_RAND_DELAY_EN
      check(tag, 32'(lat >= 2 && lat <= 9), 32'd1);
`else
      check(tag, 32'(lat), 32'd2);
`endif
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a >= BASE) && (off < 32'h4000);
   endfunction

   function automatic logic [11:0] widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off[13:2];
   endfunction

   task automatic push_read(input logic [31:0] a);
      exp_t e;
      if (in_rng(a)) begin
         e.data = model[widx(a)];
         e.resp = 2'b00;
      end else begin
         e.data = 32'h0;
         e.resp = 2'b10;
      end
      rq.push_back(e);
   endtask

   task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] m;
      if (in_rng(a)) begin
         m = model[widx(a)];
         for (int i = 0; i < 4; i++)
            if (s[i]) m[8*i +: 8] = d[8*i +: 8];
         model[widx(a)] = m;
         bq.push_back(2'b00);
      end else begin
         bq.push_back(2'b10);
      end
   endtask

   task automatic ar_phase(input logic [31:0] a);
      int t = 0;
      bus.araddr = a;
      bus.arvalid = 1'b1;
      #1;
      while (!bus.arready && t < BOUND) begin @(negedge clock); t++; end
      check("ar_wait", 32'(t < BOUND), 32'd1);
      r_hs_cyc = cyc;
      @(negedge clock);
      bus.arvalid = 1'b0;
   endtask

   task automatic r_phase(input int hold);
      int t = 0;
      exp_t e;
      logic [31:0] d0;
      logic [1:0]  r0;
      bus.rready = (hold == 0);
      #1;
      while (!bus.rvalid && t < BOUND) begin @(negedge clock); t++; end
      check("r_wait", 32'(t < BOUND), 32'd1);
      check_lat("r_latency", cyc - r_hs_cyc);
      d0 = bus.rdata;
      r0 = bus.rresp;
      for (int k = 0; k < hold; k++) begin
         @(negedge clock);
         check("r_hold_valid", 32'(bus.rvalid), 32'd1);
         check("r_hold_data", bus.rdata, d0);
         check("r_hold_resp", 32'(bus.rresp), 32'(r0));
      end
      bus.rready = 1'b1;
      check("rq_nonempty", 32'(rq.size() > 0), 32'd1);
      if (rq.size() > 0) begin
         e = rq.pop_front();
         check("rdata", bus.rdata, e.data);
         check("rresp", 32'(bus.rresp), 32'(e.resp));
      end
      @(negedge clock);
      bus.rready = 1'b0;
      check("r_drop", 32'(bus.rvalid), 32'd0);
   endtask

   task automatic aw_phase(input logic [31:0] a);
      int t = 0;
      bus.awaddr = a;
      bus.awvalid = 1'b1;
      #1;
      while (!bus.awready && t < BOUND) begin @(negedge clock); t++; end
      check("aw_wait", 32'(t < BOUND), 32'd1);
      @(negedge clock);
      bus.awvalid = 1'b0;
   endtask

   task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
      int t = 0;
      bus.wdata = d;
      bus.wstrb = s;
      bus.wvalid = 1'b1;
      #1;
      while (!bus.wready && t < BOUND) begin @(negedge clock); t++; end
      check("w_wait", 32'(t < BOUND), 32'd1);
      w_hs_cyc = cyc;
      @(negedge clock);
      bus.wvalid = 1'b0;
   endtask

   task automatic b_phase();
      int t = 0;
      logic [1:0] e;
      bus.bready = 1'b1;
      #1;
      while (!bus.bvalid && t < BOUND) begin @(negedge clock); t++; end
      check("b_wait", 32'(t < BOUND), 32'd1);
      check_lat("b_latency", cyc - w_hs_cyc);
      check("bq_nonempty", 32'(bq.size() > 0), 32'd1);
      if (bq.size() > 0) begin
         e = bq.pop_front();
         check("bresp", 32'(bus.bresp), 32'(e));
      end
      @(negedge clock);
      bus.bready = 1'b0;
      check("b_drop", 32'(bus.bvalid), 32'd0);
   endtask

   task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      push_write(a, d, s);
      aw_phase(a);
      w_phase(d, s);
      b_phase();
   endtask

   task automatic read_txn(input logic [31:0] a, input int hold);
      push_read(a);
      ar_phase(a);
      r_phase(hold);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      int k;
      bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awaddr = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_arready", 32'(bus.arready), 32'd1);
      check("rst_awready", 32'(bus.awready), 32'd1);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_wready", 32'(bus.wready), 32'd0);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_rresp", 32'(bus.rresp), 32'd0);
      check("rst_bresp", 32'(bus.bresp), 32'd0);
      @(negedge clock);

      // basic write then read
      write_txn(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
      read_txn(32'h8000_0010, 0);

      // byte-lane merge, empty strobe, ignored low address bits
      write_txn(32'h8000_0020, 32'h1122_3344, 4'hF);
      write_txn(32'h8000_0020, 32'hAABB_CCDD, 4'b0010);
      read_txn(32'h8000_0020, 0);
      write_txn(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000);
      read_txn(32'h8000_0023, 0);

      // range boundaries: below base, one past end (must not alias word 0), last word
      write_txn(BASE, 32'h0BAD_F00D, 4'hF);
      read_txn(32'h7FFF_FFFC, 0);
      write_txn(BASE + 32'h4000, 32'h1234_5678, 4'hF);
      read_txn(BASE, 0);
      write_txn(BASE + 32'h3FFC, 32'hCAFE_0001, 4'hF);
      read_txn(BASE + 32'h3FFC, 1);

      // simultaneous AR/AW: read first, AW held pending, rready stalled
      write_txn(32'h8000_0030, 32'h0101_0101, 4'hF);
      push_read(32'h8000_0030);
      push_write(32'h8000_0030, 32'h5A5A_5A5A, 4'hF);
      bus.araddr = 32'h8000_0030; bus.arvalid = 1'b1;
      bus.awaddr = 32'h8000_0030; bus.awvalid = 1'b1;
      #1;
      check("both_awready", 32'(bus.awready), 32'd0);
      check("both_arready", 32'(bus.arready), 32'd1);
      r_hs_cyc = cyc;
      @(negedge clock);
      bus.arvalid = 1'b0;
      #1;
      check("pend_awready", 32'(bus.awready), 32'd0);
      r_phase(5);
      check("idle_after_r", 32'(bus.awready), 32'd1);
      aw_phase(32'h8000_0030);
      w_phase(32'h5A5A_5A5A, 4'hF);
      b_phase();
      read_txn(32'h8000_0030, 0);

      // reset while in W_DATA: write abandoned
      write_txn(32'h8000_0040, 32'h1234_5678, 4'hF);
      aw_phase(32'h8000_0040);
      check("in_w_data", 32'(bus.wready), 32'd1);
      bus.wdata = 32'hFFFF_FFFF;
      bus.wstrb = 4'hF;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("wrst_bvalid", 32'(bus.bvalid), 32'd0);
      check("wrst_wready", 32'(bus.wready), 32'd0);
      check("wrst_arready", 32'(bus.arready), 32'd1);
      check("wrst_rdata", bus.rdata, 32'h0);
      @(negedge clock);
      read_txn(32'h8000_0040, 0);

      // randomized mix over a small window plus out-of-range hits
      for (int i = 0; i < 16; i++)
         write_txn(32'h8000_0100 + 32'(4 * i), $urandom, 4'hF);
      for (int i = 0; i < 100; i++) begin
         k = int'($urandom_range(0, 15));
         a = 32'h8000_0100 + 32'(4 * k) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) == 1) ? (32'h8000_4000 + 32'(4 * k)) : 32'h7FFF_FFF0;
         if ($urandom_range(0, 1) == 1)
            write_txn(a, $urandom, 4'($urandom_range(0, 15)));
         else
            read_txn(a, int'($urandom_range(0, 2)));
      end

      check("rq_drained", 32'(rq.size()), 32'd0);
      check("bq_drained", 32'(bq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
